rom_loader: RTL and testbench

ROM_LOADER -- requirements
Module: rom_loader

---
 rtl/rom_loader_pkg.sv | 32 +++
 rtl/rom_loader_asm.sv | 32 +++
 rtl/rom_loader.sv | 144 ++++++++++++++
 tb/tb_rom_loader.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_loader_pkg.sv
// Shared FSM encoding and word-assembly constants for the ROM loader.
// ROM_LOADER_CHECKSUM_EN adds the CSUM state and a trailing checksum byte.
package rom_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BCNT_W         = $clog2(BYTES_PER_WORD);
    localparam int LEN_W          = 16;

`ifdef ROM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_LEN0 = 3'd0,
        ST_LEN1 = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    localparam state_t ST_AFTER_DATA = ST_CSUM;
`else
    typedef enum logic [2:0] {
        ST_LEN0 = 3'd0,
        ST_LEN1 = 3'd1,
        ST_DATA = 3'd2,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    localparam state_t ST_AFTER_DATA = ST_DONE;
`endif

endpackage

// File: rtl/rom_loader_asm.sv
// Byte-to-word assembler: little-endian shift register with a 2-bit byte counter.
// o_word_done flags the byte that completes a word; o_word is valid alongside it.
module rom_loader_asm
    import rom_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_push,
    input  logic [7:0]  i_byte,
    output logic        o_word_done,
    output logic [31:0] o_word
);

    logic [BCNT_W-1:0] r_bcnt;
    logic [31:0]       r_shift;

    // Bytes enter at the top and shift down, so the first byte ends in bits 7:0.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_bcnt  <= '0;
            r_shift <= '0;
        end else if (i_push) begin
            r_bcnt  <= r_bcnt + BCNT_W'(1);
            r_shift <= {i_byte, r_shift[31:8]};
        end
    end

    assign o_word_done = i_push && (r_bcnt == BCNT_W'(BYTES_PER_WORD - 1));
    assign o_word      = {i_byte, r_shift[31:8]};

endmodule

// File: rtl/rom_loader.sv
// Streams a length-prefixed image into the core's instruction ROM write port, holding the
// core in reset until the image is complete. ROM_LOADER_CHECKSUM_EN enables a trailing checksum.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_waddr,
    output logic [31:0]       rom_wdata,
    output logic              core_hold,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [LEN_W:0] ONE_X     = {{LEN_W{1'b0}}, 1'b1};
    localparam logic [LEN_W:0] MAX_WORDS = ONE_X << ADDR_W;

    state_t            r_state;
    state_t            w_next;
    logic [LEN_W-1:0]  r_len;
    logic [ADDR_W-1:0] r_wcnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [31:0]       r_wdata;

    logic              w_accept;
    logic              w_push;
    logic              w_clear;
    logic              w_word_done;
    logic [31:0]       w_word;
    logic [LEN_W-1:0]  w_len_full;
    logic              w_len_zero;
    logic              w_oversize;
    logic              w_last_word;

    assign w_accept    = rx_valid && rx_ready;
    assign w_push      = w_accept && (r_state == ST_DATA);
    assign w_clear     = w_accept && (r_state == ST_LEN1);
    assign w_len_full  = {rx_data, r_len[7:0]};
    assign w_len_zero  = (w_len_full == '0);
    assign w_oversize  = ({1'b0, w_len_full} > MAX_WORDS);
    assign w_last_word = ({{(LEN_W + 1 - ADDR_W){1'b0}}, r_wcnt} == ({1'b0, r_len} - ONE_X));

    rom_loader_asm u_asm (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_clear),
        .i_push      (w_push),
        .i_byte      (rx_data),
        .o_word_done (w_word_done),
        .o_word      (w_word)
    );

`ifdef ROM_LOADER_CHECKSUM_EN
    logic [7:0] r_sum;
    logic       w_sum_ok;

    assign w_sum_ok = ((r_sum + rx_data) == 8'h00);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum <= 8'h00;
        end else if (w_push) begin
            r_sum <= r_sum + rx_data;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_LEN0;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_LEN0: begin
                if (w_accept) w_next = ST_LEN1;
            end
            ST_LEN1: begin
                if (w_accept) begin
                    if (w_len_zero)      w_next = ST_AFTER_DATA;
                    else if (w_oversize) w_next = ST_ERR;
                    else                 w_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_word_done && w_last_word) w_next = ST_AFTER_DATA;
            end
`ifdef ROM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (w_accept) w_next = w_sum_ok ? ST_DONE : ST_ERR;
            end
`endif
            default: ;
        endcase
    end

    // DONE is entered with the final write still in flight; completion shows a cycle later.
    always_comb begin
        rx_ready  = 1'b0;
        load_done = 1'b0;
        load_err  = 1'b0;
        case (r_state)
            ST_DONE: load_done = !r_we && !rst;
            ST_ERR:  load_err  = !rst;
            default: rx_ready  = !rst;
        endcase
        core_hold = !load_done;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len   <= '0;
            r_wcnt  <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= w_word_done;
            if (w_accept && (r_state == ST_LEN0)) r_len[7:0]       <= rx_data;
            if (w_accept && (r_state == ST_LEN1)) r_len[LEN_W-1:8] <= rx_data;
            if (w_word_done) begin
                r_waddr <= r_wcnt;
                r_wdata <= w_word;
                r_wcnt  <= r_wcnt + ADDR_W'(1);
            end
        end
    end

    assign rom_we    = r_we;
    assign rom_waddr = r_waddr;
    assign rom_wdata = r_wdata;

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: byte streams built from a word-list model, ROM writes
// captured by a monitor and compared with the expected image. Honours ROM_LOADER_CHECKSUM_EN.
module tb_rom_loader;

    localparam int AW  = 4;
    localparam int CAP = 1 << AW;
`ifdef ROM_LOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_ready;
    logic          rom_we;
    logic [AW-1:0] rom_waddr;
    logic [31:0]   rom_wdata;
    logic          core_hold;
    logic          load_done;
    logic          load_err;

    rom_loader #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .rom_we    (rom_we),
        .rom_waddr (rom_waddr),
        .rom_wdata (rom_wdata),
        .core_hold (core_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [AW+31:0] wq[$];
    int             done_cyc = -1;
    int             last_byte_cyc = 0;
    logic [31:0]    img[$];
    logic [7:0]     bytes_q[$];

    always @(negedge clk) begin
        if (rom_we) wq.push_back({rom_waddr, rom_wdata});
        if (load_done && done_cyc < 0) done_cyc = cyc;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check($sformatf("%s.rx_ready", tag),  rx_ready,  0);
        check($sformatf("%s.rom_we", tag),    rom_we,    0);
        check($sformatf("%s.rom_waddr", tag), rom_waddr, 0);
        check($sformatf("%s.rom_wdata", tag), rom_wdata, 0);
        check($sformatf("%s.core_hold", tag), core_hold, 1);
        check($sformatf("%s.load_done", tag), load_done, 0);
        check($sformatf("%s.load_err", tag),  load_err,  0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
        end
    endtask

    task automatic present(input logic [7:0] b);
        @(negedge clk);
        rx_valid      = 1'b1;
        rx_data       = b;
        last_byte_cyc = cyc;
    endtask

    task automatic reset_dut(input string tag, input bit do_chk);
        @(negedge clk);
        rst      = 1'b1;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        if (do_chk) check_reset_vals(tag);
        rst = 1'b0;
        wq.delete();
        done_cyc = -1;
        #1;
        if (do_chk) check($sformatf("%s.ready_after_rst", tag), rx_ready, 1);
    endtask

    task automatic random_img(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back($urandom);
    endtask

    // Byte stream from the word list: 16-bit count LSB first, words little-endian, then checksum.
    task automatic build(input int n);
        logic [7:0]  sum;
        logic [31:0] w;
        logic [15:0] len;
        sum = 8'h00;
        len = 16'(n);
        bytes_q.delete();
        bytes_q.push_back(len[7:0]);
        bytes_q.push_back(len[15:8]);
        if (n <= CAP) begin
            for (int i = 0; i < n; i++) begin
                w = img[i];
                for (int k = 0; k < 4; k++) begin
                    bytes_q.push_back(w[8*k +: 8]);
                    sum = sum + w[8*k +: 8];
                end
            end
            if (CSUM_ON) bytes_q.push_back(8'h00 - sum);
        end
    endtask

    task automatic send(input int mode);
        foreach (bytes_q[i]) begin
            present(bytes_q[i]);
            if (mode == 1)      idle($urandom_range(0, 2));
            else if (mode == 2) idle(1);
        end
        idle(3);
    endtask

    task automatic verify(input string tag, input int n, input bit exp_done);
        int nwr;
        int lim;
        nwr = (n <= CAP) ? n : 0;
        check($sformatf("%s.nwr", tag), wq.size(), nwr);
        lim = (wq.size() < img.size()) ? wq.size() : img.size();
        for (int i = 0; i < lim; i++)
            check($sformatf("%s.wr%0d", tag, i), wq[i], {i[AW-1:0], img[i]});
        check($sformatf("%s.load_done", tag), load_done, exp_done);
        check($sformatf("%s.core_hold", tag), core_hold, !exp_done);
        check($sformatf("%s.load_err", tag),  load_err,  !exp_done);
        check($sformatf("%s.rx_ready", tag),  rx_ready,  0);
        if (exp_done)
            check($sformatf("%s.done_cycle", tag), done_cyc,
                  last_byte_cyc + 1 + ((n > 0 && !CSUM_ON) ? 1 : 0));
    endtask

    initial begin
        int n;

        reset_dut("init", 1'b1);

        img = '{32'h00000093, 32'hDEADBEEF};
        build(2);
        send(0);
        verify("n2", 2, 1'b1);

        present(8'h55);
        present(8'hAA);
        idle(3);
        check("done_ignore.nwr", wq.size(), 2);
        check("done_ignore.load_done", load_done, 1);

        for (int t = 0; t < 3; t++) begin
            reset_dut("rand", 1'b0);
            n = (t == 2) ? CAP : $urandom_range(1, CAP - 1);
            random_img(n);
            build(n);
            send(1);
            verify($sformatf("rand%0d_n%0d", t, n), n, 1'b1);
        end

        reset_dut("n0", 1'b0);
        img.delete();
        build(0);
        send(0);
        verify("n0", 0, 1'b1);

        reset_dut("ovr", 1'b0);
        img.delete();
        build(CAP + 1);
        send(0);
        verify("ovr", CAP + 1, 1'b0);
        for (int i = 0; i < 6; i++) present(8'($urandom));
        idle(3);
        check("ovr_ignore.nwr", wq.size(), 0);
        check("ovr_ignore.load_err", load_err, 1);
        check("ovr_ignore.rx_ready", rx_ready, 0);

`ifdef ROM_LOADER_CHECKSUM_EN
        reset_dut("cs_ok", 1'b0);
        img = '{32'h04030201};
        build(1);
        bytes_q[bytes_q.size() - 1] = 8'hF6;
        send(0);
        verify("cs_ok", 1, 1'b1);

        reset_dut("cs_bad", 1'b0);
        build(1);
        bytes_q[bytes_q.size() - 1] = 8'hF5;
        send(0);
        verify("cs_bad", 1, 1'b0);
`else
        reset_dut("w1", 1'b0);
        img = '{32'h04030201};
        build(1);
        send(0);
        verify("w1", 1, 1'b1);
`endif

        // Mid-load abort: toggling valid, reset after six data bytes, then a fresh load.
        reset_dut("abort", 1'b0);
        random_img(4);
        build(4);
        for (int i = 0; i < 8; i++) begin
            present(bytes_q[i]);
            idle(1);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("abort");
        check("abort.nwr", wq.size(), 1);
        if (wq.size() > 0) check("abort.wr0", wq[0], {{AW{1'b0}}, img[0]});
        rst = 1'b0;
        #1;
        check("abort.ready_after_rst", rx_ready, 1);
        idle(4);
        check("abort.idle_nwr", wq.size(), 1);
        wq.delete();
        done_cyc = -1;
        random_img(2);
        build(2);
        send(2);
        verify("reload", 2, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
